// File: rtl/multi_one_pulse.sv
// Multi-channel button front end: debounces each channel and emits a one-cycle
// pulse per press, with optional auto-repeat and a first-press-wins round lockout.
module multi_one_pulse #(
  parameter int CHANNELS      = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1,
  parameter int LOCKOUT       = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] sypush,
  input  logic                enable,
  output logic [CHANNELS-1:0] held,
  output logic [CHANNELS-1:0] pulse,
  output logic                tie
);

  localparam int CW   = $clog2(STABLE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0]       CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]       DLY_V    = TW'(REPEAT_DELAY);
  localparam logic [TW-1:0]       PER_V    = TW'(REPEAT_PERIOD);
  localparam logic [TW-1:0]       TMR_ONE  = TW'(1);
  localparam logic [CHANNELS-1:0] ONE      = CHANNELS'(1);

  logic [CW-1:0]       cnt   [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];
  logic [TW-1:0]       tmr   [CHANNELS];
  logic [TW-1:0]       tmr_d [CHANNELS];
  logic [CHANNELS-1:0] rep_ph, rep_ph_d;
  logic [CHANNELS-1:0] held_d, press_ev, release_ev;
  logic [CHANNELS-1:0] rep_cand, cand, press_ok, gen;
  logic                lock, lock_d, tie_d;

  // Debounce: a differing level must be seen STABLE_CYCLES edges in a row.
  always_comb begin
    held_d     = held;
    press_ev   = '0;
    release_ev = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt[i];
      if (sypush[i] == held[i]) begin
        cnt_d[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        cnt_d[i]      = '0;
        held_d[i]     = ~held[i];
        press_ev[i]   = ~held[i];
        release_ev[i] = held[i];
      end else begin
        cnt_d[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Repeat timer reads j at the j-th edge after the pulse that (re)loaded it.
  always_comb begin
    rep_cand = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if ((REPEAT_DELAY != 0) && (tmr[i] != '0) && !release_ev[i] &&
          (tmr[i] == (rep_ph[i] ? PER_V : DLY_V)))
        rep_cand[i] = 1'b1;
    end
  end

  // Arbitration: under lockout only the lowest-index candidate wins.
  always_comb begin
    press_ok = press_ev & {CHANNELS{enable}};
    cand     = (press_ev | rep_cand) & {CHANNELS{enable}};
    gen      = cand;
    tie_d    = 1'b0;
    lock_d   = 1'b0;
    if (LOCKOUT != 0) begin
      if (lock) begin
        gen = '0;
      end else begin
        gen   = cand & (~cand + ONE);
        tie_d = (press_ok & (press_ok - ONE)) != '0;
      end
      if (|gen)
        lock_d = 1'b1;
      else if (held == '0)
        lock_d = 1'b0;
      else
        lock_d = lock;
    end
  end

  // A repeat slot that lockout suppressed still reloads the timer.
  always_comb begin
    rep_ph_d = rep_ph;
    for (int i = 0; i < CHANNELS; i++) begin
      tmr_d[i] = tmr[i];
      if (!enable || release_ev[i] || (REPEAT_DELAY == 0)) begin
        tmr_d[i]    = '0;
        rep_ph_d[i] = 1'b0;
      end else if (gen[i] && press_ev[i]) begin
        tmr_d[i]    = TMR_ONE;
        rep_ph_d[i] = 1'b0;
      end else if (tmr[i] != '0) begin
        if (rep_cand[i]) begin
          tmr_d[i]    = TMR_ONE;
          rep_ph_d[i] = 1'b1;
        end else begin
          tmr_d[i] = tmr[i] + TMR_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held   <= '0;
      pulse  <= '0;
      tie    <= 1'b0;
      lock   <= 1'b0;
      rep_ph <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
        tmr[i] <= '0;
      end
    end else begin
      held   <= held_d;
      pulse  <= gen;
      tie    <= tie_d;
      lock   <= lock_d;
      rep_ph <= rep_ph_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= cnt_d[i];
        tmr[i] <= tmr_d[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_one_pulse.sv
// Bench for multi_one_pulse: four configurations checked every cycle against a
// time-stamp based reference model, plus directed spec-timing checks.
module tb_multi_one_pulse;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [1:0] sy      [4];
  logic [1:0] held_o  [4];
  logic [1:0] pulse_o [4];
  logic       tie_o   [4];

  always #5 clk = ~clk;

  // dut 0: plain, 1: repeat 8/3, 2: lockout, 3: single-sample debounce with repeat 2/1
  multi_one_pulse #(.CHANNELS(2), .STABLE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(1), .LOCKOUT(0))
    dut_a (.clk(clk), .rst(rst), .sypush(sy[0]), .enable(en), .held(held_o[0]), .pulse(pulse_o[0]), .tie(tie_o[0]));
  multi_one_pulse #(.CHANNELS(2), .STABLE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .LOCKOUT(0))
    dut_r (.clk(clk), .rst(rst), .sypush(sy[1]), .enable(en), .held(held_o[1]), .pulse(pulse_o[1]), .tie(tie_o[1]));
  multi_one_pulse #(.CHANNELS(2), .STABLE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(1), .LOCKOUT(1))
    dut_l (.clk(clk), .rst(rst), .sypush(sy[2]), .enable(en), .held(held_o[2]), .pulse(pulse_o[2]), .tie(tie_o[2]));
  multi_one_pulse #(.CHANNELS(2), .STABLE_CYCLES(1), .REPEAT_DELAY(2), .REPEAT_PERIOD(1), .LOCKOUT(0))
    dut_s (.clk(clk), .rst(rst), .sypush(sy[3]), .enable(en), .held(held_o[3]), .pulse(pulse_o[3]), .tie(tie_o[3]));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int st [4] = '{4, 4, 4, 1};
  int rd [4] = '{0, 8, 0, 2};
  int rp [4] = '{1, 3, 1, 1};
  int lk [4] = '{0, 0, 1, 0};

  // Reference model: a level flips once it has disagreed for st cycles since the
  // last agreeing edge; repeats are scheduled as absolute edge times.
  logic [1:0] m_held  [4];
  logic [1:0] e_pulse [4];
  logic       e_tie   [4];
  logic       m_lock  [4];
  int         anchor  [4][2];
  int         nf      [4][2];
  logic [1:0] mh, mpress, mrel, mrep, mcand, mgen, mpc;
  logic       mtie;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        m_held[d] <= 2'b00; e_pulse[d] <= 2'b00; e_tie[d] <= 1'b0; m_lock[d] <= 1'b0;
        for (int c = 0; c < 2; c++) begin anchor[d][c] <= cyc; nf[d][c] <= -1; end
      end else begin
        mh = m_held[d]; mpress = 2'b00; mrel = 2'b00; mrep = 2'b00; mtie = 1'b0;
        for (int c = 0; c < 2; c++) begin
          if (sy[d][c] == m_held[d][c]) anchor[d][c] <= cyc;
          else if (cyc - anchor[d][c] >= st[d]) begin
            mh[c] = ~mh[c]; anchor[d][c] <= cyc;
            mpress[c] = mh[c]; mrel[c] = ~mh[c];
          end
          mrep[c] = (rd[d] > 0) && (nf[d][c] == cyc) && !mrel[c];
        end
        mcand = (mpress | mrep) & {2{en}};
        mgen  = mcand;
        if (lk[d] != 0) begin
          if (m_lock[d]) mgen = 2'b00;
          else begin
            mgen = mcand[0] ? 2'b01 : (mcand[1] ? 2'b10 : 2'b00);
            mpc  = mpress & {2{en}};
            mtie = (mpc == 2'b11);
          end
          m_lock[d] <= (mgen != 2'b00) ? 1'b1 : ((m_held[d] == 2'b00) ? 1'b0 : m_lock[d]);
        end
        for (int c = 0; c < 2; c++) begin
          if (!en || mrel[c] || rd[d] == 0) nf[d][c] <= -1;
          else if (mgen[c] && mpress[c]) nf[d][c] <= cyc + rd[d];
          else if (nf[d][c] == cyc) nf[d][c] <= cyc + rp[d];
        end
        m_held[d] <= mh; e_pulse[d] <= mgen; e_tie[d] <= mtie;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (held_o[d] !== 2'b00 || pulse_o[d] !== 2'b00 || tie_o[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset dut%0d got held=%b pulse=%b tie=%b exp 00/00/0", d, held_o[d], pulse_o[d], tie_o[d]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_debounce();
    int first_p = -1, first_h = -1, np0 = 0, np1 = 0;
    for (int n = 0; n < 18; n++) begin
      sy[0] = (n < 10) ? 2'b01 : 2'b00;
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (held_o[d] !== m_held[d] || pulse_o[d] !== e_pulse[d] || tie_o[d] !== e_tie[d]) begin
          errors++;
          $display("FAIL debounce_model dut%0d n=%0d got %b/%b/%b exp %b/%b/%b", d, n, held_o[d], pulse_o[d], tie_o[d], m_held[d], e_pulse[d], e_tie[d]);
        end
      end
      if (pulse_o[0][0]) begin np0++; if (first_p < 0) first_p = n; end
      if (pulse_o[0][1]) np1++;
      if (held_o[0][0] && first_h < 0) first_h = n;
    end
    checks++; if (np0 !== 1) begin errors++; $display("FAIL debounce_count got=%0d exp=1", np0); end
    checks++; if (first_p !== 3) begin errors++; $display("FAIL debounce_pulse_time got=%0d exp=3", first_p); end
    checks++; if (first_h !== 3) begin errors++; $display("FAIL debounce_held_time got=%0d exp=3", first_h); end
    checks++; if (np1 !== 0) begin errors++; $display("FAIL debounce_other_ch got=%0d exp=0", np1); end
  endtask

  task automatic test_glitch();
    int np0 = 0, np1 = 0, h1 = 0, t0 = -1;
    for (int n = 0; n < 30; n++) begin
      sy[0][1] = (n < 3);
      sy[0][0] = (n >= 10 && n < 23 && n != 12);
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (held_o[d] !== m_held[d] || pulse_o[d] !== e_pulse[d] || tie_o[d] !== e_tie[d]) begin
          errors++;
          $display("FAIL glitch_model dut%0d n=%0d got %b/%b/%b exp %b/%b/%b", d, n, held_o[d], pulse_o[d], tie_o[d], m_held[d], e_pulse[d], e_tie[d]);
        end
      end
      if (pulse_o[0][0]) begin np0++; t0 = n; end
      if (pulse_o[0][1]) np1++;
      if (held_o[0][1]) h1++;
    end
    checks++; if (np1 !== 0 || h1 !== 0) begin errors++; $display("FAIL glitch_short got pulses=%0d held=%0d exp 0/0", np1, h1); end
    checks++; if (np0 !== 1 || t0 !== 16) begin errors++; $display("FAIL glitch_bounce got count=%0d at=%0d exp 1 at 16", np0, t0); end
  endtask

  task automatic test_repeat();
    logic exp_p;
    for (int n = 0; n < 40; n++) begin
      sy[1] = (n < 30) ? 2'b01 : 2'b00;
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (held_o[d] !== m_held[d] || pulse_o[d] !== e_pulse[d] || tie_o[d] !== e_tie[d]) begin
          errors++;
          $display("FAIL repeat_model dut%0d n=%0d got %b/%b/%b exp %b/%b/%b", d, n, held_o[d], pulse_o[d], tie_o[d], m_held[d], e_pulse[d], e_tie[d]);
        end
      end
      // first pulse at 3, first repeat 8 later, then every 3 until release lands at 33
      exp_p = (n == 3) || (n >= 11 && n < 33 && ((n - 11) % 3) == 0);
      checks++;
      if (pulse_o[1] !== {1'b0, exp_p}) begin
        errors++; $display("FAIL repeat_timing n=%0d got=%b exp=%b", n, pulse_o[1], {1'b0, exp_p});
      end
    end
  endtask

  task automatic test_lockout();
    logic [1:0] exp_p;
    logic       exp_t;
    for (int n = 0; n < 70; n++) begin
      case (n / 10)
        0: sy[2] = 2'b10;
        1: sy[2] = 2'b11;
        3: sy[2] = 2'b01;
        5: sy[2] = 2'b11;
        default: sy[2] = 2'b00;
      endcase
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (held_o[d] !== m_held[d] || pulse_o[d] !== e_pulse[d] || tie_o[d] !== e_tie[d]) begin
          errors++;
          $display("FAIL lockout_model dut%0d n=%0d got %b/%b/%b exp %b/%b/%b", d, n, held_o[d], pulse_o[d], tie_o[d], m_held[d], e_pulse[d], e_tie[d]);
        end
      end
      exp_p = (n == 3) ? 2'b10 : ((n == 33 || n == 53) ? 2'b01 : 2'b00);
      exp_t = (n == 53);
      checks++;
      if (pulse_o[2] !== exp_p || tie_o[2] !== exp_t) begin
        errors++; $display("FAIL lockout_seq n=%0d got pulse=%b tie=%b exp pulse=%b tie=%b", n, pulse_o[2], tie_o[2], exp_p, exp_t);
      end
    end
  endtask

  task automatic test_enable();
    for (int n = 0; n < 16; n++) begin
      sy[0] = (n < 12) ? 2'b01 : 2'b00;
      en    = (n >= 6);
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (held_o[d] !== m_held[d] || pulse_o[d] !== e_pulse[d] || tie_o[d] !== e_tie[d]) begin
          errors++;
          $display("FAIL enable_model dut%0d n=%0d got %b/%b/%b exp %b/%b/%b", d, n, held_o[d], pulse_o[d], tie_o[d], m_held[d], e_pulse[d], e_tie[d]);
        end
      end
      checks++;
      if (pulse_o[0] !== 2'b00 || held_o[0][0] !== (n >= 3 && n < 15)) begin
        errors++; $display("FAIL enable_gate n=%0d got pulse=%b held=%b exp pulse=00 held0=%b", n, pulse_o[0], held_o[0], (n >= 3 && n < 15));
      end
    end
    en = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic exp_p, exp_h;
    for (int n = 0; n < 32; n++) begin
      sy[1] = (n < 26) ? 2'b01 : 2'b00;
      rst   = (n == 16);
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (held_o[d] !== m_held[d] || pulse_o[d] !== e_pulse[d] || tie_o[d] !== e_tie[d]) begin
          errors++;
          $display("FAIL midrst_model dut%0d n=%0d got %b/%b/%b exp %b/%b/%b", d, n, held_o[d], pulse_o[d], tie_o[d], m_held[d], e_pulse[d], e_tie[d]);
        end
      end
      exp_p = (n == 3 || n == 11 || n == 14 || n == 20 || n == 28);
      exp_h = (n >= 3 && n < 16) || (n >= 20 && n < 29);
      checks++;
      if (pulse_o[1] !== {1'b0, exp_p} || held_o[1] !== {1'b0, exp_h}) begin
        errors++; $display("FAIL midrst_seq n=%0d got pulse=%b held=%b exp pulse=%b held=%b", n, pulse_o[1], held_o[1], {1'b0, exp_p}, {1'b0, exp_h});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_p;
    for (int n = 0; n < 10; n++) begin
      sy[3] = (n < 6) ? 2'b01 : 2'b00;
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (held_o[d] !== m_held[d] || pulse_o[d] !== e_pulse[d] || tie_o[d] !== e_tie[d]) begin
          errors++;
          $display("FAIL b2b_model dut%0d n=%0d got %b/%b/%b exp %b/%b/%b", d, n, held_o[d], pulse_o[d], tie_o[d], m_held[d], e_pulse[d], e_tie[d]);
        end
      end
      exp_p = (n == 0) || (n >= 2 && n < 6);
      checks++;
      if (pulse_o[3] !== {1'b0, exp_p} || held_o[3] !== {1'b0, n < 6}) begin
        errors++; $display("FAIL b2b_seq n=%0d got pulse=%b held=%b exp pulse=%b", n, pulse_o[3], held_o[3], {1'b0, exp_p});
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 2; c++)
          if ($urandom_range(0, 5) == 0) sy[d][c] = ~sy[d][c];
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (held_o[d] !== m_held[d] || pulse_o[d] !== e_pulse[d] || tie_o[d] !== e_tie[d]) begin
          errors++;
          $display("FAIL random_model dut%0d n=%0d got %b/%b/%b exp %b/%b/%b", d, n, held_o[d], pulse_o[d], tie_o[d], m_held[d], e_pulse[d], e_tie[d]);
        end
      end
    end
    rst = 1'b0;
    en  = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 4; d++) sy[d] = 2'b00;
    test_reset();
    test_debounce();
    test_glitch();
    test_repeat();
    test_lockout();
    test_enable();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_one_pulse.md
# multi_one_pulse

Parametrised successor to the game's single-button one-pulse stage. Takes CHANNELS already-synchronised push-button levels, debounces each channel, and emits a one-cycle pulse per debounced press, with optional auto-repeat while held. An optional round lockout lets only the first press through until every button is released. Sits between the input synchronisers and the tug-of-war scoring/round logic.

## Interface
- CHANNELS, 2: number of independent button channels (≥1)
- STABLE_CYCLES, 4: consecutive samples a new level must persist before `held` changes (≥1)
- REPEAT_DELAY, 0: cycles from the first pulse to the first auto-repeat pulse; 0 disables auto-repeat
- REPEAT_PERIOD, 1: cycles between successive auto-repeat pulses (≥1; ignored if REPEAT_DELAY=0)
- LOCKOUT, 0: 1 = after any pulse, suppress all pulses until all `held` bits are low

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- sypush  in  CHANNELS  synchronised raw button levels, bit i = channel i
- enable  in  1  1 = pulses allowed; 0 = pulses suppressed, debounce keeps running
- held  out  CHANNELS  registered debounced level per channel
- pulse  out  CHANNELS  registered one-cycle press pulse per channel
- tie  out  1  registered; high for one cycle when lockout arbitration dropped a simultaneous press

## Operation
- Reset (rst=1 at an edge): held=0, pulse=0, tie=0, all debounce counters=0, all repeat timers=0, lock=0. Reset overrides everything, including mid-debounce and mid-repeat.
- Debounce, per channel: counter width $clog2(STABLE_CYCLES+1). At each edge, if sypush[i]==held[i], counter clears. Otherwise, counter increments. When the incremented value would equal STABLE_CYCLES, held[i] toggles and the counter clears.
- Press event: held[i] toggling 0→1 at an edge. Release is held[i] toggling 1→0; it produces no pulse.
- Pulse generation: pulse[i] is high in the cycle after the edge where the press event occurs, for exactly one cycle, provided enable=1 at that edge and the lockout does not block it.
- Auto-repeat (REPEAT_DELAY>0): per-channel timer starts at the press pulse.
  - If held[i] is still 1 REPEAT_DELAY cycles after the press pulse, pulse[i] fires again.
  - Thereafter, pulse[i] fires every REPEAT_PERIOD cycles while held[i]=1.
  - Timer clears on release, on enable=0, or on rst.
- Lockout (LOCKOUT=1): lock sets at the edge any pulse is generated and blocks all press and repeat pulses. lock clears at the first edge where all held bits are 0.
  - If several channels press on the same edge while unlocked, only the lowest index pulses, and tie=1 for that cycle.
  - With LOCKOUT=0, simultaneous presses all pulse and tie stays 0.
- enable=0: pulse forced 0, repeat timers cleared, held and debounce unaffected. A press whose event edge has enable=0 is lost; it is not replayed when enable returns.

## Timing
- Latency: with sypush[i] rising before edge k and held stable, held[i] and pulse[i] both go high after edge k+STABLE_CYCLES-1. Example: STABLE_CYCLES=4 gives pulse in the cycle after edge k+3.
- STABLE_CYCLES=1: held follows sypush with one register delay, and pulse fires one cycle after the rise.
- A glitch shorter than STABLE_CYCLES samples never changes held and never pulses.
- Auto-repeat pulses are spaced exactly REPEAT_DELAY cycles after the first pulse, then exactly REPEAT_PERIOD cycles apart, measured pulse-rise to pulse-rise.
- At most one pulse per channel per cycle. pulse is never high on two consecutive cycles unless REPEAT_PERIOD=1 during repeat.
- No combinational path from input to output.

## Test plan
- Reset/debounce, CHANNELS=2, STABLE_CYCLES=4: rst for 2 cycles, then sypush[0]=1 held 10 cycles -> held[0] rises after the 4th sampling edge; pulse[0] high for exactly 1 cycle; pulse[1] stays 0.
- Glitch rejection, STABLE_CYCLES=4: sypush[1] high for 3 cycles, then low -> held[1] and pulse[1] stay 0. Bounce pattern 1,1,0,1,1,1,1 -> single pulse after the last four 1s.
- Auto-repeat, REPEAT_DELAY=8, REPEAT_PERIOD=3: hold sypush[0] 30 cycles -> pulses at t0, t0+8, t0+11, t0+14, …; release stops repeats within STABLE_CYCLES cycles.
- Lockout, LOCKOUT=1: press ch1 then ch0 while ch1 held -> only ch1 pulses. Release both, then press ch0 -> ch0 pulses. Press both on the same edge -> pulse=2'b01 and tie=1 for one cycle.
- Enable gating: enable=0 during a press edge -> no pulse, held rises. Raise enable while still held -> no late pulse.
- Mid-operation reset: assert rst while held=1 and repeat active -> next cycle held=0, pulse=0, lock=0. With button still down after rst release, a fresh pulse arrives STABLE_CYCLES later.
